dmem_arbiter: RTL and testbench

- Two-port arbiter sharing the single-ported data memory between port 0 (CPU load/store stage) and port 1 (secondary master, e.g. loader/debug DMA).
- Sequences one memory access per grant and drives the memory's address, write-data, write-enable and read-enable inputs.
- Captures read data into a per-port register and returns a one-cycle acknowledge.
- Port 0 has fixed priority, with a starvation limit that guarantees port 1 progress.

---
 rtl/dmem_arbiter_if.sv | 17 +
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Per-requester bus of dmem_arbiter: command toward the arbiter, completion back.
// The requester holds req/we/addr/wdata stable until it sees ack.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input  ack, rdata, err);
  modport slave  (input  req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: port 0 has priority,
// port 1 is forced through after STARVE_MAX back-to-back port-0 grants.
// Optional address range check: define DMEM_ARB_RANGE_CHK_EN.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_MAX   = 4,
  parameter int ADDR_LIMIT_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     port0,
  dmem_arbiter_if.slave     port1,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Command of the port currently owning the memory.
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              own_oob;

  assign own_we    = owner_q ? port1.we    : port0.we;
  assign own_addr  = owner_q ? port1.addr  : port0.addr;
  assign own_wdata = owner_q ? port1.wdata : port0.wdata;
  assign own_oob   = RANGE_CHK && (|own_addr[ADDR_W-1:ADDR_LIMIT_W]);

  // Memory strobes are decoded straight from the state so a reset in the middle
  // of ACCESS removes the write enable before the next edge can commit it.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (!reset && state_q == ACCESS) begin
      mem_access_addr = own_addr;
      mem_write_data  = own_wdata;
      mem_write_en    = own_we  & ~own_oob;
      mem_read        = ~own_we & ~own_oob;
    end
  end

  always_comb begin
    // NOTE: every _d signal gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (port0.req || port1.req) begin
          state_d = ACCESS;
          if (port0.req && !(port1.req && starve_cnt_q == STARVE_LIM)) begin
            owner_d = 1'b0;
            // The forced-grant check above keeps the count below the limit here.
            starve_cnt_d = port1.req ? starve_cnt_q + 4'd1 : 4'd0;
          end else begin
            owner_d      = 1'b1;
            starve_cnt_d = 4'd0;
          end
        end
      end

      ACCESS: begin
        state_d = RESP;
        if (owner_q) begin
          ack1_d = 1'b1;
          err1_d = own_oob;
          if (own_oob)     rdata1_d = '0;
          else if (!own_we) rdata1_d = mem_read_data;
        end else begin
          ack0_d = 1'b1;
          err0_d = own_oob;
          if (own_oob)     rdata0_d = '0;
          else if (!own_we) rdata0_d = mem_read_data;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= 4'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge value
      // of the others regardless of statement order.
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign port0.ack   = ack0_q;
  assign port1.ack   = ack1_q;
  assign port0.err   = err0_q;
  assign port1.err   = err1_q;
  assign port0.rdata = rdata0_q;
  assign port1.rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus randomized back-to-back
// traffic compared against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 32;
  localparam int STARVE_MAX   = 4;
  localparam int ADDR_LIMIT_W = 9;

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { int port; logic [31:0] rdata; bit err; int cyc; } resp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) p0_if ();
  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) p1_if ();

  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_write_en;
  logic              mem_read;

  dmem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .STARVE_MAX(STARVE_MAX), .ADDR_LIMIT_W(ADDR_LIMIT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .port0(p0_if), .port1(p1_if),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // Environment memory: 256 words, combinational read, write at the clock edge.
  logic [31:0] mem_words [256] = '{default: '0};
  assign mem_read_data = mem_words[mem_access_addr[9:2]];
  always @(posedge clk) if (mem_write_en) mem_words[mem_access_addr[9:2]] <= mem_write_data;

  int wr_cycles = 0;
  always @(negedge clk) if (mem_write_en) wr_cycles <= wr_cycles + 1;

  // Reference state
  logic [31:0] ref_mem [256] = '{default: '0};
  logic [31:0] ref_rdata [2] = '{default: '0};
  txn_t  q0[$], q1[$];
  resp_t expq[$], got[$];
  bit    both_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  function automatic bit is_oob(input logic [31:0] addr);
    return RCHK && (addr >= 32'(2 ** ADDR_LIMIT_W));
  endfunction

  // Apply one completed transaction to the reference state; returns expected response.
  function automatic resp_t model_apply(input int port, input txn_t t);
    resp_t r;
    bit oob = is_oob(t.addr);
    if (t.we && !oob) ref_mem[t.addr[9:2]] = t.wdata;
    if (oob)        ref_rdata[port] = '0;
    else if (!t.we) ref_rdata[port] = ref_mem[t.addr[9:2]];
    r.port = port; r.rdata = ref_rdata[port]; r.err = oob; r.cyc = 0;
    return r;
  endfunction

  int          lat;
  logic [31:0] rd, acc_addr;
  logic        er, acc_wr, acc_rd;

  // Single transaction on one port; records latency, response and ACCESS-cycle strobes.
  task automatic txn(input int port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata);
    txn_t  t;
    resp_t r;
    lat = -1; rd = '0; er = 1'b0; acc_addr = '0; acc_wr = 1'b0; acc_rd = 1'b0;
    @(posedge clk); #1;
    set_port(port, 1'b1, we, addr, wdata);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin acc_addr = mem_access_addr; acc_wr = mem_write_en; acc_rd = mem_read; end
      if ((port == 0) ? p0_if.ack : p1_if.ack) begin
        lat = k;
        rd  = (port == 0) ? p0_if.rdata : p1_if.rdata;
        er  = (port == 0) ? p0_if.err   : p1_if.err;
        break;
      end
    end
    @(posedge clk); #1;
    set_port(port, 1'b0, 1'b0, '0, '0);
    t.we = we; t.addr = addr; t.wdata = wdata;
    r = model_apply(port, t);
  endtask

  // Predict grant order and responses for both queues presented back-to-back.
  task automatic predict(input txn_t a[$], input txn_t b[$]);
    int   cnt = 0;
    int   g;
    txn_t t;
    expq.delete();
    while (a.size() != 0 || b.size() != 0) begin
      if (a.size() != 0 && b.size() != 0) g = (cnt == STARVE_MAX) ? 1 : 0;
      else                                g = (a.size() != 0) ? 0 : 1;
      if (g == 0) begin
        cnt = (b.size() != 0) ? ((cnt < STARVE_MAX) ? cnt + 1 : cnt) : 0;
        t = a.pop_front();
      end else begin
        cnt = 0;
        t = b.pop_front();
      end
      expq.push_back(model_apply(g, t));
    end
  endtask

  // Drive both queues; each requester presents its next item on the edge ending its ack.
  task automatic run_queues(input int budget);
    bit a0, a1;
    got.delete();
    @(posedge clk); #1;
    if (q0.size() != 0) set_port(0, 1'b1, q0[0].we, q0[0].addr, q0[0].wdata);
    if (q1.size() != 0) set_port(1, 1'b1, q1[0].we, q1[0].addr, q1[0].wdata);
    for (int cyc = 0; cyc < budget && (q0.size() != 0 || q1.size() != 0); cyc++) begin
      @(negedge clk);
      a0 = p0_if.ack; a1 = p1_if.ack;
      if (a0 && a1) both_ack = 1'b1;
      if (a0) got.push_back('{port: 0, rdata: p0_if.rdata, err: p0_if.err, cyc: cyc});
      if (a1) got.push_back('{port: 1, rdata: p1_if.rdata, err: p1_if.err, cyc: cyc});
      @(posedge clk); #1;
      if (a0 && q0.size() != 0) begin
        void'(q0.pop_front());
        if (q0.size() != 0) set_port(0, 1'b1, q0[0].we, q0[0].addr, q0[0].wdata);
        else                set_port(0, 1'b0, 1'b0, '0, '0);
      end
      if (a1 && q1.size() != 0) begin
        void'(q1.pop_front());
        if (q1.size() != 0) set_port(1, 1'b1, q1[0].we, q1[0].addr, q1[0].wdata);
        else                set_port(1, 1'b0, 1'b0, '0, '0);
      end
    end
    check("queues_drained", q0.size() + q1.size(), 0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      check($sformatf("%s_port[%0d]", tag, i), got[i].port, expq[i].port);
      check($sformatf("%s_rdata[%0d]", tag, i), got[i].rdata, expq[i].rdata);
      check($sformatf("%s_err[%0d]", tag, i), got[i].err, expq[i].err);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = 32'($urandom_range(0, 255)) << 2;
    t.wdata = $urandom;
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    txn_t t;

    // Reset state
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_ack0", p0_if.ack, 0);
    check("rst_ack1", p1_if.ack, 0);
    check("rst_err", {p0_if.err, p1_if.err}, 0);
    check("rst_rdata0", p0_if.rdata, 0);
    check("rst_rdata1", p1_if.rdata, 0);
    check("rst_mem_out", {mem_access_addr, mem_write_data, mem_write_en, mem_read}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_mem_out", {mem_access_addr, mem_write_en, mem_read}, 0);

    // Basic write then read on port 0
    w0 = wr_cycles;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
    check("wr_latency", lat, 3);
    check("wr_we_cycles", wr_cycles - w0, 1);
    check("wr_acc_addr", acc_addr, 32'h10);
    check("wr_acc_we", acc_wr, 1);
    check("wr_err", er, 0);
    txn(0, 1'b0, 32'h10, 32'h0);
    check("rd_latency", lat, 3);
    check("rd_rdata0", rd, 32'hDEADBEEF);
    check("rd_acc_read", acc_rd, 1);
    check("rd_acc_we", acc_wr, 0);

    // Simultaneous reads: port 0 first, port 1 three cycles later
    txn(0, 1'b1, 32'h80, 32'h11112222);
    txn(1, 1'b1, 32'h84, 32'h33334444);
    q0 = '{'{we: 1'b0, addr: 32'h80, wdata: 32'h0}};
    q1 = '{'{we: 1'b0, addr: 32'h84, wdata: 32'h0}};
    predict(q0, q1);
    run_queues(50);
    compare_log("dual");
    if (got.size() == 2) check("dual_spacing", got[1].cyc - got[0].cyc, 3);
    else                 check("dual_ack_count", got.size(), 2);
    check("dual_rdata1", p1_if.rdata, 32'h33334444);

    // Starvation limit: both held, 8 port-0 and 2 port-1 reads
    q0.delete(); q1.delete();
    for (int i = 0; i < 8; i++) q0.push_back('{we: 1'b0, addr: 32'(i) << 2, wdata: 32'h0});
    for (int i = 0; i < 2; i++) q1.push_back('{we: 1'b0, addr: 32'h100 + (32'(i) << 2), wdata: 32'h0});
    predict(q0, q1);
    run_queues(100);
    compare_log("starve");
    for (int i = 0; i < 10 && i < got.size(); i++)
      check($sformatf("starve_pattern[%0d]", i), got[i].port, pat[i]);
    for (int i = 0; i + 1 < got.size(); i++)
      check($sformatf("starve_spacing[%0d]", i), got[i+1].cyc - got[i].cyc, 3);

    // Randomized back-to-back traffic
    for (int r = 0; r < 3; r++) begin
      q0.delete(); q1.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) q0.push_back(rand_txn());
      for (int i = 0; i < $urandom_range(1, 12); i++) q1.push_back(rand_txn());
      predict(q0, q1);
      run_queues(400);
      compare_log($sformatf("rand%0d", r));
    end

    // Reset during the ACCESS cycle of a write
    txn(0, 1'b1, 32'h20, 32'hCAFEF00D);
    txn(0, 1'b0, 32'h20, 32'h0);
    check("pre_rst_rdata0", rd, 32'hCAFEF00D);
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    @(negedge clk);
    check("mid_access_we", mem_write_en, 1);
    reset = 1'b1;
    #1;
    check("rst_we_async", mem_write_en, 0);
    check("rst_rdata0_cleared", p0_if.rdata, 0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rst_no_ack0", p0_if.ack, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ref_rdata = '{default: '0};
    @(negedge clk);
    check("post_rst_no_ack0", p0_if.ack, 0);
    txn(0, 1'b0, 32'h20, 32'h0);
    check("post_rst_latency", lat, 3);
    check("post_rst_old_value", rd, 32'hCAFEF00D);

    // Address range boundary on port 1
    w0 = wr_cycles;
    txn(1, 1'b1, 32'h200, 32'h5A5A0000);
    check("oob_latency", lat, 3);
    check("oob_we_cycles", wr_cycles - w0, RCHK ? 0 : 1);
    check("oob_err1", er, RCHK);
    txn(1, 1'b0, 32'h1FC, 32'h0);
    check("inrange_err1", er, 0);
    check("inrange_latency", lat, 3);

    // rdata1 holds across port-0 writes
    txn(1, 1'b1, 32'h40, 32'hA5A5A5A5);
    txn(1, 1'b0, 32'h40, 32'h0);
    check("hold_rd1", rd, 32'hA5A5A5A5);
    txn(0, 1'b1, 32'h44, 32'h01020304);
    txn(0, 1'b1, 32'h40, 32'h0);
    check("hold_rdata1", p1_if.rdata, 32'hA5A5A5A5);

    check("acks_exclusive", both_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
